// File: rtl/common_types_pkg.sv
// Shared types and constants for the execute-stage multiplier.
// Consumed by multiplier.sv; early termination is selected there with MULT_EARLY_TERM_EN.
package common_types_pkg;

  localparam int MULT_XLEN  = 32;
  localparam int MULT_CNT_W = $clog2(MULT_XLEN);

  typedef enum logic [1:0] {
    MULT_IDLE,
    MULT_BUSY,
    MULT_FINISH
  } mult_state_t;

  // Two's complement magnitude, taken only when the operand is signed and negative.
  function automatic logic [MULT_XLEN-1:0] mult_mag(input logic [MULT_XLEN-1:0] v,
                                                    input logic                 is_signed);
    return (is_signed && v[MULT_XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/multiplier.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module multiplier
  import common_types_pkg::*;
#(
  parameter int XLEN = MULT_XLEN
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            start,
  input  logic            abort,
  input  logic            mult_signed_a,
  input  logic            mult_signed_b,
  input  logic            mult_half,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mult_state_t           state, state_next;
  logic [2*XLEN-1:0]     mcand;
  logic [2*XLEN-1:0]     prod;
  logic [XLEN-1:0]       mplr;
  logic [MULT_CNT_W-1:0] cnt;
  logic                  neg;
  logic                  half;

  logic [XLEN-1:0]       a_mag, b_mag;
  logic                  accept;
  logic                  last_step;
  logic                  b_zero;
  logic [2*XLEN-1:0]     prod_sum;
  logic [2*XLEN-1:0]     prod_final;
  logic [XLEN-1:0]       res_sel;

  assign a_mag  = mult_mag(a, mult_signed_a);
  assign b_mag  = mult_mag(b, mult_signed_b);
  assign accept = start && !abort;

`ifdef MULT_EARLY_TERM_EN
  assign b_zero    = (b_mag == '0);
  assign last_step = (cnt == '0) || (mplr[XLEN-1:1] == '0);
`else
  assign b_zero    = 1'b0;
  assign last_step = (cnt == '0);
`endif

  // Result is captured on the edge into FINISH, so it is built from this cycle's sum.
  assign prod_sum   = prod + (mplr[0] ? mcand : '0);
  assign prod_final = neg ? (~prod_sum + 1'b1) : prod_sum;
  assign res_sel    = half ? prod_final[2*XLEN-1:XLEN] : prod_final[XLEN-1:0];

  assign busy = (state != MULT_IDLE);
  assign done = (state == MULT_FINISH) && !abort;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      MULT_IDLE:   if (accept) state_next = b_zero ? MULT_FINISH : MULT_BUSY;
      MULT_BUSY:   if (last_step) state_next = MULT_FINISH;
      MULT_FINISH: state_next = MULT_IDLE;
      default:     state_next = MULT_IDLE;
    endcase
    if (abort) state_next = MULT_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= MULT_IDLE;
      mcand  <= '0;
      prod   <= '0;
      mplr   <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      half   <= 1'b0;
      result <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        MULT_IDLE: begin
          if (accept) begin
            mcand <= {{XLEN{1'b0}}, a_mag};
            mplr  <= b_mag;
            prod  <= '0;
            cnt   <= MULT_CNT_W'(XLEN - 1);
            neg   <= (mult_signed_a & a[XLEN-1]) ^ (mult_signed_b & b[XLEN-1]);
            half  <= mult_half;
            if (b_zero) result <= '0;
          end
        end
        MULT_BUSY: begin
          if (!abort) begin
            prod  <= prod_sum;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            if (cnt != '0) cnt <= cnt - 1'b1;
            if (state_next == MULT_FINISH) result <= res_sel;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
